pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage RV32IM pipeline. Each cycle it decides whether the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers load, hold or are loaded with a bubble. Decisions cover memory busywait, load-use hazards, taken branches/jumps and multi-cycle MUL/DIV occupancy of EX. It sits beside the datapath and drives the per-register BUSYWAIT (hold) and flush inputs; MUL/DIV occupancy is tracked with a small counter FSM.

## Interface
- MUL_LATENCY, 4: EX stall cycles for MUL/MULH/MULHSU/MULHU; must be ≥2.
- DIV_LATENCY, 32: EX stall cycles for DIV/DIVU/REM/REMU; must be ≥2.
- CNT_W, 6: counter width; must hold max(MUL_LATENCY, DIV_LATENCY)-2.
- CLK  in  1  single clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-high.
- ID_RS1, ID_RS2  in  5  source register numbers of the instruction in ID.
- ID_RS1_USED, ID_RS2_USED  in  1  the corresponding source is actually read.
- EX_RD  in  5  destination register of the instruction in EX.
- EX_MEM_READ  in  1  the instruction in EX is a load.
- EX_BRANCH_TAKEN  in  1  branch/jump in EX resolved taken.
- EX_MULDIV  in  1  the instruction in EX is a valid MUL/DIV-class op.
- EX_IS_DIV  in  1  qualifies EX_MULDIV: 1 = divide/remainder, 0 = multiply.
- IMEM_BUSYWAIT, DMEM_BUSYWAIT  in  1  instruction/data memory not ready.
- PC_HOLD  out  1  PC keeps its value.
- IF_ID_BUSYWAIT, ID_EX_BUSYWAIT, EX_MEM_BUSYWAIT, MEM_WB_BUSYWAIT  out  1  the register holds its contents.
- IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH  out  1  the register loads a bubble (all fields zero, REG_WRITE_EN=0, READ_WRITE=0).
- MULDIV_RESULT_VALID  out  1  EX MUL/DIV result is valid this cycle.

## Operation
- All outputs are combinational from the inputs and FSM state. HOLD overrides FLUSH on the same register.
- Priority 1, DMEM_BUSYWAIT: PC and all four registers hold; no flushes.
- Priority 2, IMEM_BUSYWAIT: PC and IF_ID hold. IF_ID_FLUSH is asserted only if EX_BRANCH_TAKEN; later stages advance normally.
- Priority 3, MUL/DIV stall (FSM in IDLE with EX_MULDIV, or in BUSY): PC, IF_ID and ID_EX hold; EX_MEM_FLUSH asserted.
- Priority 4, EX_BRANCH_TAKEN: IF_ID_FLUSH and ID_EX_FLUSH asserted; PC loads the target.
- Priority 5, load-use hazard: condition is EX_MEM_READ && EX_RD!=0 && ((ID_RS1_USED && ID_RS1==EX_RD) || (ID_RS2_USED && ID_RS2==EX_RD)). PC and IF_ID hold; ID_EX_FLUSH asserted.
- Otherwise all outputs are 0.
- FSM states:
  - IDLE: on EX_MULDIV, load cnt with (EX_IS_DIV ? DIV_LATENCY : MUL_LATENCY)-2 and go to BUSY.
  - BUSY: while cnt!=0, decrement cnt. When cnt==0, go to DONE.
  - DONE: MULDIV_RESULT_VALID=1 and no MUL/DIV stall. Go to IDLE on a cycle without DMEM_BUSYWAIT; otherwise remain in DONE.
- DMEM_BUSYWAIT during BUSY: cnt keeps counting, because the unit is independent of memory.
- DONE never re-triggers, so the op leaves EX exactly once. Back-to-back MUL/DIV ops each get their full latency.

## Timing
- Reset:
  - State = IDLE, cnt = 0.
  - While RESET is high, all outputs are 0 regardless of inputs.
- MUL/DIV: exactly L stall cycles (1 in IDLE plus L-1 in BUSY), then one DONE cycle in which the op advances into EX/MEM.
- Load-use: exactly one bubble. On the next cycle EX_MEM_READ refers to the bubble, so the hazard clears.
- Taken branch: two bubbles (IF_ID and ID_EX) inserted at the same edge.
- RESET mid-BUSY: IDLE on the next edge; the pending op is discarded.

## Configuration
- MULDIV_STALL_EN defined: FSM and counter are compiled in; behaviour as above.
- MULDIV_STALL_EN undefined:
  - No FSM or counter. MUL/DIV is treated as single-cycle.
  - Priority 3 never fires; MULDIV_RESULT_VALID = EX_MULDIV.
  - MUL_LATENCY, DIV_LATENCY and CNT_W are ignored.

## Structure
- Shared utils header holds the FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the bubble/zero constants used by all pipeline registers.
- One sub-module, muldiv_stall_fsm: holds the state and cnt and outputs stall and result_valid. It is instantiated only under MULDIV_STALL_EN.

## Test plan
- Load-use: EX_MEM_READ=1, EX_RD=5, ID_RS1=5, ID_RS1_USED=1 → one cycle of PC_HOLD=IF_ID_BUSYWAIT=ID_EX_FLUSH=1; same with EX_RD=0 → all outputs 0.
- Branch over load-use: EX_BRANCH_TAKEN=1 together with the hazard above → IF_ID_FLUSH=ID_EX_FLUSH=1, PC_HOLD=0.
- MUL: EX_MULDIV=1, EX_IS_DIV=0, MUL_LATENCY=4 → ID_EX_BUSYWAIT=1 and EX_MEM_FLUSH=1 for exactly 4 cycles, then MULDIV_RESULT_VALID=1 for 1 cycle.
- DIV with DMEM_BUSYWAIT=1 for cycles 10–40 after start (DIV_LATENCY=32) → DONE reached at cycle 32 and held; returns to IDLE the cycle after busywait drops; all registers held for cycles 10–40.
- RESET asserted in cycle 3 of a DIV → all outputs 0 that cycle; IDLE next cycle; a fresh EX_MULDIV restarts the full 32-cycle count.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: MUL/DIV FSM state
// encodings, bubble/zero constants for the pipeline registers, hazard helper.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   // Field values a pipeline register takes when it is loaded with a bubble.
   localparam logic [4:0]  REG_ZERO            = 5'd0;
   localparam logic [31:0] BUBBLE_WORD         = 32'd0;
   localparam logic        BUBBLE_REG_WRITE_EN = 1'b0;
   localparam logic        BUBBLE_READ_WRITE   = 1'b0;

   function automatic logic load_use_hazard(
      input logic       ex_mem_read,
      input logic [4:0] ex_rd,
      input logic [4:0] id_rs1,
      input logic       id_rs1_used,
      input logic [4:0] id_rs2,
      input logic       id_rs2_used
   );
      return ex_mem_read && (ex_rd != REG_ZERO) &&
             ((id_rs1_used && (id_rs1 == ex_rd)) ||
              (id_rs2_used && (id_rs2 == ex_rd)));
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_muldiv_stall_fsm.sv
// MUL/DIV occupancy tracker for the EX stage: keeps EX stalled for the op's
// full latency, then flags one result-valid cycle before re-arming.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no op in flight; a new MUL/DIV in EX stalls and loads cnt
// BUSY    | op executing; stall while cnt counts down to zero
// DONE    | result valid, op may leave EX; waits out any DMEM busywait
module muldiv_stall_fsm
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MUL_LATENCY = 4,
   parameter int DIV_LATENCY = 32,
   parameter int CNT_W       = 6
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ex_muldiv_i,
   input  logic ex_is_div_i,
   input  logic dmem_busywait_i,
   output logic stall_o,
   output logic result_valid_o
);

   // The IDLE cycle already counts as one stall cycle and BUSY spends one
   // cycle at cnt==0, hence the -2.
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 2);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LATENCY - 2);

   muldiv_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      stall_o        = 1'b0;
      result_valid_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ex_muldiv_i) begin
               stall_o = 1'b1;
               cnt_d   = ex_is_div_i ? DIV_CNT : MUL_CNT;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            stall_o = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            result_valid_o = 1'b1;
            if (!dmem_busywait_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage RV32IM pipeline.
// Multi-cycle MUL/DIV stalls are compiled in only when MULDIV_STALL_EN is defined.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MUL_LATENCY = 4,
   parameter int DIV_LATENCY = 32,
   parameter int CNT_W       = 6
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [4:0] ID_RS1,
   input  logic [4:0] ID_RS2,
   input  logic       ID_RS1_USED,
   input  logic       ID_RS2_USED,
   input  logic [4:0] EX_RD,
   input  logic       EX_MEM_READ,
   input  logic       EX_BRANCH_TAKEN,
   input  logic       EX_MULDIV,
   input  logic       EX_IS_DIV,
   input  logic       IMEM_BUSYWAIT,
   input  logic       DMEM_BUSYWAIT,
   output logic       PC_HOLD,
   output logic       IF_ID_BUSYWAIT,
   output logic       ID_EX_BUSYWAIT,
   output logic       EX_MEM_BUSYWAIT,
   output logic       MEM_WB_BUSYWAIT,
   output logic       IF_ID_FLUSH,
   output logic       ID_EX_FLUSH,
   output logic       EX_MEM_FLUSH,
   output logic       MULDIV_RESULT_VALID
);

   logic muldiv_stall;
   logic muldiv_valid;
   logic hazard;

`ifdef MULDIV_STALL_EN
   localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;

   if (MUL_LATENCY < 2 || DIV_LATENCY < 2 || (MAX_LAT - 2) >= (1 << CNT_W)) begin : g_bad_cfg
      $error("pipeline_hazard_ctrl: latencies must be >= 2 and fit in CNT_W");
   end

   muldiv_stall_fsm #(
      .MUL_LATENCY (MUL_LATENCY),
      .DIV_LATENCY (DIV_LATENCY),
      .CNT_W       (CNT_W)
   ) u_muldiv_stall_fsm (
      .clk_i           (CLK),
      .rst_i           (RESET),
      .ex_muldiv_i     (EX_MULDIV),
      .ex_is_div_i     (EX_IS_DIV),
      .dmem_busywait_i (DMEM_BUSYWAIT),
      .stall_o         (muldiv_stall),
      .result_valid_o  (muldiv_valid)
   );
`else
   // MUL/DIV behaves as a single-cycle op: no occupancy state at all.
   localparam int unused_cfg_sum = MUL_LATENCY + DIV_LATENCY + CNT_W;
   logic unused_is_div;
   logic unused_clk;
   assign unused_is_div = EX_IS_DIV;
   assign unused_clk    = CLK;
   assign muldiv_stall  = 1'b0;
   assign muldiv_valid  = EX_MULDIV;
`endif

   assign hazard = load_use_hazard(EX_MEM_READ, EX_RD, ID_RS1, ID_RS1_USED,
                                   ID_RS2, ID_RS2_USED);

   always_comb begin
      PC_HOLD             = 1'b0;
      IF_ID_BUSYWAIT      = 1'b0;
      ID_EX_BUSYWAIT      = 1'b0;
      EX_MEM_BUSYWAIT     = 1'b0;
      MEM_WB_BUSYWAIT     = 1'b0;
      IF_ID_FLUSH         = 1'b0;
      ID_EX_FLUSH         = 1'b0;
      EX_MEM_FLUSH        = 1'b0;
      MULDIV_RESULT_VALID = 1'b0;
      if (!RESET) begin
         MULDIV_RESULT_VALID = muldiv_valid;
         if (DMEM_BUSYWAIT) begin
            PC_HOLD         = 1'b1;
            IF_ID_BUSYWAIT  = 1'b1;
            ID_EX_BUSYWAIT  = 1'b1;
            EX_MEM_BUSYWAIT = 1'b1;
            MEM_WB_BUSYWAIT = 1'b1;
         end else if (IMEM_BUSYWAIT) begin
            PC_HOLD        = 1'b1;
            IF_ID_BUSYWAIT = 1'b1;
            IF_ID_FLUSH    = EX_BRANCH_TAKEN;
         end else if (muldiv_stall) begin
            PC_HOLD        = 1'b1;
            IF_ID_BUSYWAIT = 1'b1;
            ID_EX_BUSYWAIT = 1'b1;
            EX_MEM_FLUSH   = 1'b1;
         end else if (EX_BRANCH_TAKEN) begin
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
         end else if (hazard) begin
            PC_HOLD        = 1'b1;
            IF_ID_BUSYWAIT = 1'b1;
            ID_EX_FLUSH    = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// random traffic, all checked against a stall-countdown reference model.
module tb_pipeline_hazard_ctrl;

   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 32;

`ifdef MULDIV_STALL_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RESET;
   logic [4:0] ID_RS1, ID_RS2, EX_RD;
   logic       ID_RS1_USED, ID_RS2_USED, EX_MEM_READ, EX_BRANCH_TAKEN;
   logic       EX_MULDIV, EX_IS_DIV, IMEM_BUSYWAIT, DMEM_BUSYWAIT;
   logic       PC_HOLD, IF_ID_BUSYWAIT, ID_EX_BUSYWAIT, EX_MEM_BUSYWAIT, MEM_WB_BUSYWAIT;
   logic       IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MULDIV_RESULT_VALID;

   always #5 CLK = ~CLK;

   pipeline_hazard_ctrl #(
      .MUL_LATENCY (MUL_LAT),
      .DIV_LATENCY (DIV_LAT),
      .CNT_W       (6)
   ) dut (
      .CLK                 (CLK),
      .RESET               (RESET),
      .ID_RS1              (ID_RS1),
      .ID_RS2              (ID_RS2),
      .ID_RS1_USED         (ID_RS1_USED),
      .ID_RS2_USED         (ID_RS2_USED),
      .EX_RD               (EX_RD),
      .EX_MEM_READ         (EX_MEM_READ),
      .EX_BRANCH_TAKEN     (EX_BRANCH_TAKEN),
      .EX_MULDIV           (EX_MULDIV),
      .EX_IS_DIV           (EX_IS_DIV),
      .IMEM_BUSYWAIT       (IMEM_BUSYWAIT),
      .DMEM_BUSYWAIT       (DMEM_BUSYWAIT),
      .PC_HOLD             (PC_HOLD),
      .IF_ID_BUSYWAIT      (IF_ID_BUSYWAIT),
      .ID_EX_BUSYWAIT      (ID_EX_BUSYWAIT),
      .EX_MEM_BUSYWAIT     (EX_MEM_BUSYWAIT),
      .MEM_WB_BUSYWAIT     (MEM_WB_BUSYWAIT),
      .IF_ID_FLUSH         (IF_ID_FLUSH),
      .ID_EX_FLUSH         (ID_EX_FLUSH),
      .EX_MEM_FLUSH        (EX_MEM_FLUSH),
      .MULDIV_RESULT_VALID (MULDIV_RESULT_VALID)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: stall cycles still owed by the op in EX, and whether its
   // result is sitting in EX waiting to leave.
   int m_stall_left = 0;
   bit m_result_ready = 1'b0;

   int cnt_idex_hold, cnt_valid, cnt_memwb_hold;

   // Bit order: PC, IF_ID_BW, ID_EX_BW, EX_MEM_BW, MEM_WB_BW, IF_ID_FL, ID_EX_FL, EX_MEM_FL, VALID
   function automatic logic [8:0] ref_out();
      logic [8:0] e;
      bit stall, lu;
      e = '0;
      if (RESET) return e;
      if (STALL_EN) begin
         stall = (m_stall_left > 0) || (!m_result_ready && EX_MULDIV);
         e[0]  = m_result_ready;
      end else begin
         stall = 1'b0;
         e[0]  = EX_MULDIV;
      end
      lu = EX_MEM_READ && (EX_RD != 0) &&
           ((ID_RS1_USED && ID_RS1 == EX_RD) || (ID_RS2_USED && ID_RS2 == EX_RD));
      if (DMEM_BUSYWAIT)        e[8:4] = 5'b11111;
      else if (IMEM_BUSYWAIT) begin
         e[8] = 1'b1; e[7] = 1'b1; e[3] = EX_BRANCH_TAKEN;
      end else if (stall) begin
         e[8] = 1'b1; e[7] = 1'b1; e[6] = 1'b1; e[1] = 1'b1;
      end else if (EX_BRANCH_TAKEN) begin
         e[3] = 1'b1; e[2] = 1'b1;
      end else if (lu) begin
         e[8] = 1'b1; e[7] = 1'b1; e[2] = 1'b1;
      end
      return e;
   endfunction

   task automatic model_edge();
      if (RESET) begin
         m_stall_left   = 0;
         m_result_ready = 1'b0;
      end else if (m_result_ready) begin
         m_result_ready = DMEM_BUSYWAIT;
      end else if (m_stall_left > 0) begin
         m_stall_left--;
         if (m_stall_left == 0) m_result_ready = 1'b1;
      end else if (EX_MULDIV) begin
         m_stall_left = (EX_IS_DIV ? DIV_LAT : MUL_LAT) - 1;
      end
   endtask

   task automatic tick(input string tag);
      logic [8:0] obs, expv;
      @(negedge CLK);
      expv = ref_out();
      obs  = {PC_HOLD, IF_ID_BUSYWAIT, ID_EX_BUSYWAIT, EX_MEM_BUSYWAIT, MEM_WB_BUSYWAIT,
              IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MULDIV_RESULT_VALID};
      cnt_idex_hold  += int'(ID_EX_BUSYWAIT);
      cnt_valid      += int'(MULDIV_RESULT_VALID);
      cnt_memwb_hold += int'(MEM_WB_BUSYWAIT);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic check_count(input string tag, input int observed, input int expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic quiet();
      RESET = 1'b0; ID_RS1 = '0; ID_RS2 = '0; EX_RD = '0;
      ID_RS1_USED = 1'b0; ID_RS2_USED = 1'b0; EX_MEM_READ = 1'b0;
      EX_BRANCH_TAKEN = 1'b0; EX_MULDIV = 1'b0; EX_IS_DIV = 1'b0;
      IMEM_BUSYWAIT = 1'b0; DMEM_BUSYWAIT = 1'b0;
   endtask

   task automatic clear_counts();
      cnt_idex_hold = 0; cnt_valid = 0; cnt_memwb_hold = 0;
   endtask

   initial begin
      clear_counts();
      // Reset with every input active: outputs must all be 0.
      RESET = 1'b1; ID_RS1 = 5'd5; ID_RS2 = 5'd5; EX_RD = 5'd5;
      ID_RS1_USED = 1'b1; ID_RS2_USED = 1'b1; EX_MEM_READ = 1'b1;
      EX_BRANCH_TAKEN = 1'b1; EX_MULDIV = 1'b1; EX_IS_DIV = 1'b1;
      IMEM_BUSYWAIT = 1'b1; DMEM_BUSYWAIT = 1'b1;
      @(posedge CLK); #1;
      tick("reset_all_on");
      tick("reset_all_on2");
      quiet();
      tick("idle");

      // Load-use on rs1, then the bubble clears it.
      EX_MEM_READ = 1'b1; EX_RD = 5'd5; ID_RS1 = 5'd5; ID_RS1_USED = 1'b1;
      tick("load_use");
      EX_MEM_READ = 1'b0; EX_RD = 5'd0;
      tick("load_use_bubble");
      EX_MEM_READ = 1'b1; EX_RD = 5'd0; ID_RS1 = 5'd0;
      tick("load_use_x0");
      quiet();
      EX_MEM_READ = 1'b1; EX_RD = 5'd9; ID_RS2 = 5'd9; ID_RS2_USED = 1'b1;
      tick("load_use_rs2");
      ID_RS2_USED = 1'b0;
      tick("load_use_rs2_unused");

      // Taken branch beats the load-use hazard.
      quiet();
      EX_MEM_READ = 1'b1; EX_RD = 5'd5; ID_RS1 = 5'd5; ID_RS1_USED = 1'b1;
      EX_BRANCH_TAKEN = 1'b1;
      tick("branch_over_lu");
      IMEM_BUSYWAIT = 1'b1;
      tick("imem_with_branch");
      quiet();

      // MUL: op sits in EX until its result is valid, then leaves.
      clear_counts();
      EX_MULDIV = 1'b1; EX_IS_DIV = 1'b0;
      for (int i = 0; i < MUL_LAT + 1; i++) tick("mul");
      EX_MULDIV = 1'b0;
      tick("mul_after");
      check_count("mul_stall_cycles", cnt_idex_hold, STALL_EN ? MUL_LAT : 0);
      check_count("mul_valid_cycles", cnt_valid, STALL_EN ? 1 : MUL_LAT + 1);

      // DIV with a long DMEM busywait overlapping the end of the count.
      clear_counts();
      EX_MULDIV = 1'b1; EX_IS_DIV = 1'b1;
      for (int i = 0; i < 46; i++) begin
         EX_MULDIV     = (i < 42);
         DMEM_BUSYWAIT = (i >= 10 && i <= 40);
         tick("div_dmem");
      end
      quiet();
      check_count("div_dmem_valid_cycles", cnt_valid, STALL_EN ? 10 : 42);
      check_count("div_dmem_memwb_hold", cnt_memwb_hold, 31);

      // Reset in the middle of a DIV, then a fresh DIV gets its full count.
      EX_MULDIV = 1'b1; EX_IS_DIV = 1'b1;
      for (int i = 0; i < 3; i++) tick("div_pre_reset");
      RESET = 1'b1;
      tick("div_reset");
      RESET = 1'b0;
      clear_counts();
      begin
         int budget = 0;
         while (cnt_valid == 0 && budget < 60) begin
            tick("div_restart");
            budget++;
         end
         check_count("div_restart_bounded", int'(cnt_valid != 0), 1);
      end
      check_count("div_restart_stall_cycles", cnt_idex_hold, STALL_EN ? DIV_LAT : 0);
      quiet();
      tick("div_restart_after");

      // Random traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         RESET           = ($urandom_range(63) == 0);
         ID_RS1          = 5'($urandom_range(3));
         ID_RS2          = 5'($urandom_range(3));
         EX_RD           = 5'($urandom_range(3));
         ID_RS1_USED     = 1'($urandom_range(1));
         ID_RS2_USED     = 1'($urandom_range(1));
         EX_MEM_READ     = 1'($urandom_range(1));
         EX_BRANCH_TAKEN = ($urandom_range(3) == 0);
         EX_MULDIV       = ($urandom_range(4) == 0);
         EX_IS_DIV       = ($urandom_range(2) == 0);
         IMEM_BUSYWAIT   = ($urandom_range(6) == 0);
         DMEM_BUSYWAIT   = ($urandom_range(6) == 0);
         tick("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
